// File: rtl/vae_stream_sequencer_if.sv
// 64-bit AXI-Stream bundle used for both the input and the result stream.
`timescale 1ns/1ps
interface vae_stream_sequencer_if;
   logic [63:0] tdata;
   logic        tvalid;
   logic        tlast;
   logic        tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/vae_stream_sequencer.sv
// Control sequencer for the VAE core: streams one packet into four weight/input BRAMs,
// runs the core, then streams the output BRAM back out.
`timescale 1ns/1ps
module vae_stream_sequencer #(
   parameter int N_WB2M = 9,
   parameter int N_WB2V = 9,
   parameter int N_WB3  = 9,
   parameter int N_XIN  = 9,
   parameter int N_XOUT = 9,
   parameter int ADDR_W = 4
) (
   input  logic                  aclk,
   input  logic                  areset,
   vae_stream_sequencer_if.slave  s_axis,
   vae_stream_sequencer_if.master m_axis,
   output logic                  wb2_m_ena,
   output logic [ADDR_W-1:0]     wb2_m_addra,
   output logic [63:0]           wb2_m_dina,
   output logic [7:0]            wb2_m_wea,
   output logic                  wb2_v_ena,
   output logic [ADDR_W-1:0]     wb2_v_addra,
   output logic [63:0]           wb2_v_dina,
   output logic [7:0]            wb2_v_wea,
   output logic                  wb3_ena,
   output logic [ADDR_W-1:0]     wb3_addra,
   output logic [63:0]           wb3_dina,
   output logic [7:0]            wb3_wea,
   output logic                  xin_ena,
   output logic [ADDR_W-1:0]     xin_addra,
   output logic [15:0]           xin_dina,
   output logic [7:0]            xin_wea,
   input  logic                  vae_ready,
   output logic                  vae_start,
   input  logic                  vae_done,
   output logic                  xout_enb,
   output logic [ADDR_W-1:0]     xout_addrb,
   input  logic [15:0]           xout_doutb,
   output logic                  busy,
   output logic                  err_tlast
);
   localparam logic [ADDR_W-1:0] LAST_WB2M = ADDR_W'(N_WB2M - 1);
   localparam logic [ADDR_W-1:0] LAST_WB2V = ADDR_W'(N_WB2V - 1);
   localparam logic [ADDR_W-1:0] LAST_WB3  = ADDR_W'(N_WB3 - 1);
   localparam logic [ADDR_W-1:0] LAST_XIN  = ADDR_W'(N_XIN - 1);
   localparam logic [ADDR_W-1:0] LAST_XOUT = ADDR_W'(N_XOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_L_WB2M, S_L_WB2V, S_L_WB3, S_L_XIN,
      S_START, S_RUN, S_RD_ADDR, S_RD_DATA, S_SEND
   } state_t;

   state_t            r_state, w_state_nx, w_load_nx;
   logic [ADDR_W-1:0] r_cnt, w_cnt_nx, r_idx, w_idx_nx, r_waddr, w_waddr_nx, w_last_cnt;
   logic [63:0]       r_wdata, w_wdata_nx;
   logic [3:0]        r_wsel, w_wsel_nx, w_port;
   logic [15:0]       r_dout, w_dout_nx;
   logic              r_err, w_err_nx, r_start, w_start_nx;
   logic              w_load, w_last_beat, w_final;

   assign w_load = (r_state == S_L_WB2M) || (r_state == S_L_WB2V) ||
                   (r_state == S_L_WB3)  || (r_state == S_L_XIN);

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_wsel  <= '0;
         r_dout  <= '0;
         r_err   <= 1'b0;
         r_start <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_idx   <= w_idx_nx;
         r_waddr <= w_waddr_nx;
         r_wdata <= w_wdata_nx;
         r_wsel  <= w_wsel_nx;
         r_dout  <= w_dout_nx;
         r_err   <= w_err_nx;
         r_start <= w_start_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_cnt_nx    = r_cnt;
      w_idx_nx    = r_idx;
      w_waddr_nx  = r_waddr;
      w_wdata_nx  = r_wdata;
      w_wsel_nx   = '0;
      w_dout_nx   = r_dout;
      w_err_nx    = r_err;
      w_start_nx  = 1'b0;
      w_last_cnt  = '0;
      w_load_nx   = S_IDLE;
      w_port      = '0;
      case (r_state)
         S_L_WB2M: begin w_last_cnt = LAST_WB2M; w_load_nx = S_L_WB2V; w_port = 4'b0001; end
         S_L_WB2V: begin w_last_cnt = LAST_WB2V; w_load_nx = S_L_WB3;  w_port = 4'b0010; end
         S_L_WB3:  begin w_last_cnt = LAST_WB3;  w_load_nx = S_L_XIN;  w_port = 4'b0100; end
         S_L_XIN:  begin w_last_cnt = LAST_XIN;  w_load_nx = S_START;  w_port = 4'b1000; end
         default: ;
      endcase
      w_last_beat = (r_cnt == w_last_cnt);
      w_final     = (r_state == S_L_XIN) && w_last_beat;

      case (r_state)
         S_IDLE: w_state_nx = S_L_WB2M;
         S_L_WB2M, S_L_WB2V, S_L_WB3, S_L_XIN: begin
            if (s_axis.tvalid) begin
               // the beat is always written, even when its tlast forces a restart
               w_wsel_nx  = w_port;
               w_waddr_nx = r_cnt;
               w_wdata_nx = s_axis.tdata;
               if (s_axis.tlast && !w_final) begin
                  w_err_nx   = 1'b1;
                  w_cnt_nx   = '0;
                  w_state_nx = S_L_WB2M;
               end else if (w_last_beat) begin
                  w_cnt_nx   = '0;
                  w_state_nx = w_load_nx;
                  if (w_final && !s_axis.tlast) w_err_nx = 1'b1;
               end else begin
                  w_cnt_nx = r_cnt + 1'b1;
               end
            end
         end
         S_START: if (vae_ready) begin
            w_start_nx = 1'b1;
            w_state_nx = S_RUN;
         end
         S_RUN: if (vae_done) begin
            w_idx_nx   = '0;
            w_state_nx = S_RD_ADDR;
         end
         S_RD_ADDR: w_state_nx = S_RD_DATA;
         S_RD_DATA: begin
            w_dout_nx  = xout_doutb;
            w_state_nx = S_SEND;
         end
         S_SEND: if (m_axis.tready) begin
            if (r_idx == LAST_XOUT) begin
               w_state_nx = S_IDLE;
            end else begin
               w_idx_nx   = r_idx + 1'b1;
               w_state_nx = S_RD_ADDR;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   assign s_axis.tready = w_load;
   assign m_axis.tvalid = (r_state == S_SEND);
   assign m_axis.tlast  = (r_state == S_SEND) && (r_idx == LAST_XOUT);
   assign m_axis.tdata  = {r_dout, 48'h0};

   // one shared write register fans out to all four ports; r_wsel picks the live one
   assign wb2_m_ena   = r_wsel[0];
   assign wb2_m_wea   = {8{r_wsel[0]}};
   assign wb2_m_addra = r_waddr;
   assign wb2_m_dina  = r_wdata;
   assign wb2_v_ena   = r_wsel[1];
   assign wb2_v_wea   = {8{r_wsel[1]}};
   assign wb2_v_addra = r_waddr;
   assign wb2_v_dina  = r_wdata;
   assign wb3_ena     = r_wsel[2];
   assign wb3_wea     = {8{r_wsel[2]}};
   assign wb3_addra   = r_waddr;
   assign wb3_dina    = r_wdata;
   assign xin_ena     = r_wsel[3];
   assign xin_wea     = {8{r_wsel[3]}};
   assign xin_addra   = r_waddr;
   assign xin_dina    = r_wdata[63:48];

   assign vae_start  = r_start;
   assign xout_enb   = (r_state == S_RD_ADDR);
   assign xout_addrb = r_idx;
   assign busy       = (r_state != S_IDLE);
   assign err_tlast  = r_err;
endmodule

// File: tb/tb_vae_stream_sequencer.sv
// Scoreboard bench for vae_stream_sequencer: stimulus pushes expected BRAM writes and
// result beats, a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_vae_stream_sequencer;
   localparam int AW = 4;

   logic aclk = 1'b0;
   logic areset;
   always #5 aclk = ~aclk;

   vae_stream_sequencer_if s_if();
   vae_stream_sequencer_if m_if();

   logic          wb2_m_ena, wb2_v_ena, wb3_ena, xin_ena;
   logic [AW-1:0] wb2_m_addra, wb2_v_addra, wb3_addra, xin_addra;
   logic [63:0]   wb2_m_dina, wb2_v_dina, wb3_dina;
   logic [15:0]   xin_dina;
   logic [7:0]    wb2_m_wea, wb2_v_wea, wb3_wea, xin_wea;
   logic          vae_ready, vae_start, vae_done, xout_enb, busy, err_tlast;
   logic [AW-1:0] xout_addrb;
   logic [15:0]   xout_doutb;

   vae_stream_sequencer #(.ADDR_W(AW)) dut (
      .aclk(aclk), .areset(areset), .s_axis(s_if), .m_axis(m_if),
      .wb2_m_ena(wb2_m_ena), .wb2_m_addra(wb2_m_addra), .wb2_m_dina(wb2_m_dina), .wb2_m_wea(wb2_m_wea),
      .wb2_v_ena(wb2_v_ena), .wb2_v_addra(wb2_v_addra), .wb2_v_dina(wb2_v_dina), .wb2_v_wea(wb2_v_wea),
      .wb3_ena(wb3_ena), .wb3_addra(wb3_addra), .wb3_dina(wb3_dina), .wb3_wea(wb3_wea),
      .xin_ena(xin_ena), .xin_addra(xin_addra), .xin_dina(xin_dina), .xin_wea(xin_wea),
      .vae_ready(vae_ready), .vae_start(vae_start), .vae_done(vae_done),
      .xout_enb(xout_enb), .xout_addrb(xout_addrb), .xout_doutb(xout_doutb),
      .busy(busy), .err_tlast(err_tlast)
   );

   typedef struct { int port; int addr; logic [63:0] data; } wr_t;
   typedef struct { logic [63:0] data; logic last; } out_t;
   wr_t  wr_q[$];
   out_t out_q[$];

   int n_chk = 0, n_pass = 0;
   int beats_seen = 0, rd_seen = 0, n_stall = 0, start_cnt = 0;
   int stall_beat = -1, stall_left = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // output BRAM model: word i holds A000|i, one-cycle read latency
   always @(posedge aclk) if (xout_enb) xout_doutb <= 16'hA000 | {12'h0, xout_addrb};

   // core model: done pulse 20 cycles after each start
   initial begin
      vae_done = 1'b0;
      forever begin
         @(negedge aclk);
         if (vae_start === 1'b1) begin
            start_cnt++;
            repeat (20) @(negedge aclk);
            vae_done = 1'b1;
            @(negedge aclk);
            vae_done = 1'b0;
         end
      end
   end

   // downstream sink: ready except for a programmed stall on one beat
   initial begin
      m_if.tready = 1'b1;
      forever begin
         @(posedge aclk); #1;
         if (m_if.tvalid === 1'b1 && beats_seen == stall_beat && stall_left > 0) begin
            m_if.tready = 1'b0;
            stall_left--;
         end else m_if.tready = 1'b1;
      end
   end

   logic [3:0]    mon_en;
   int            mon_p, mon_a;
   logic [63:0]   mon_d, hold_d;
   logic [7:0]    mon_w;
   logic          hold_l, stalled = 1'b0;
   wr_t           mon_e;
   out_t          mon_o;
   always @(negedge aclk) begin
      mon_en = {xin_ena, wb3_ena, wb2_v_ena, wb2_m_ena};
      if (mon_en != 4'b0 && !$isunknown(mon_en)) begin
         case (mon_en)
            4'b0001: begin mon_p = 0; mon_a = int'(wb2_m_addra); mon_d = wb2_m_dina; mon_w = wb2_m_wea; end
            4'b0010: begin mon_p = 1; mon_a = int'(wb2_v_addra); mon_d = wb2_v_dina; mon_w = wb2_v_wea; end
            4'b0100: begin mon_p = 2; mon_a = int'(wb3_addra);   mon_d = wb3_dina;   mon_w = wb3_wea;   end
            4'b1000: begin mon_p = 3; mon_a = int'(xin_addra);   mon_d = {48'h0, xin_dina}; mon_w = xin_wea; end
            default: begin mon_p = -1; mon_a = -1; mon_d = '1; mon_w = '0; end
         endcase
         if (wr_q.size() == 0) chk("wr_unexpected", 64'(mon_en), 64'h0);
         else begin
            mon_e = wr_q.pop_front();
            chk("wr_port", 64'(mon_p), 64'(mon_e.port));
            chk("wr_addr", 64'(mon_a), 64'(mon_e.addr));
            chk("wr_data", mon_d, mon_e.data);
            chk("wr_wea", 64'(mon_w), 64'hFF);
         end
      end
      if (xout_enb === 1'b1) begin
         chk("rd_addr", 64'(xout_addrb), 64'(rd_seen % 9));
         rd_seen++;
      end
      if (m_if.tvalid === 1'b1 && m_if.tready === 1'b0) begin
         n_stall++;
         if (!stalled) begin hold_d = m_if.tdata; hold_l = m_if.tlast; stalled = 1'b1; end
         else begin
            chk("stall_data_stable", m_if.tdata, hold_d);
            chk("stall_last_stable", 64'(m_if.tlast), 64'(hold_l));
         end
         chk("stall_no_read", 64'(xout_enb), 64'h0);
      end
      if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
         if (out_q.size() == 0) chk("out_unexpected", 64'h1, 64'h0);
         else begin
            mon_o = out_q.pop_front();
            chk("out_data", m_if.tdata, mon_o.data);
            chk("out_last", 64'(m_if.tlast), 64'(mon_o.last));
         end
         stalled = 1'b0;
         beats_seen++;
      end
   end

   function automatic logic [63:0] beat(int k);
      return {16'h0400 + 16'(k), 16'h5A5A, 16'hC0DE, 16'(k)};
   endfunction

   // called at a negedge; returns at the negedge after the handshake edge
   task automatic send_beat(int k, logic last, int port, int addr);
      int t;
      s_if.tdata  = beat(k);
      s_if.tlast  = last;
      s_if.tvalid = 1'b1;
      wr_q.push_back('{port, addr, (port == 3) ? {48'h0, 16'h0400 + 16'(k)} : beat(k)});
      t = 0;
      while (s_if.tready !== 1'b1 && t < 200) begin @(negedge aclk); t++; end
      if (t >= 200) chk("tready_timeout", 64'h0, 64'h1);
      @(negedge aclk);
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
   endtask

   task automatic load_packet(int gap);
      for (int k = 0; k < 36; k++) begin
         send_beat(k, k == 35, k / 9, k % 9);
         if (gap != 0) @(negedge aclk);
      end
      for (int i = 0; i < 9; i++) out_q.push_back('{{16'hA000 | 16'(i), 48'h0}, i == 8});
   endtask

   task automatic finish_packet(string tag, int starts_before, logic exp_err);
      int t;
      t = 0;
      while ((out_q.size() != 0 || wr_q.size() != 0) && t < 3000) begin @(negedge aclk); t++; end
      if (t >= 3000) $display("FAIL %s_timeout: got %0d/%0d pending expected 0", tag, wr_q.size(), out_q.size());
      chk("pkt_drained", 64'(t < 3000), 64'h1);
      repeat (2) @(negedge aclk);
      chk("start_count", 64'(start_cnt - starts_before), 64'h1);
      chk("err_tlast", 64'(err_tlast), 64'(exp_err));
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_tready"}, 64'(s_if.tready), 64'h0);
      chk({tag, "_tvalid"}, 64'(m_if.tvalid), 64'h0);
      chk({tag, "_tlast"},  64'(m_if.tlast), 64'h0);
      chk({tag, "_ena"},    64'({wb2_m_ena, wb2_v_ena, wb3_ena, xin_ena}), 64'h0);
      chk({tag, "_start"},  64'(vae_start), 64'h0);
      chk({tag, "_enb"},    64'(xout_enb), 64'h0);
      chk({tag, "_busy"},   64'(busy), 64'h0);
      chk({tag, "_err"},    64'(err_tlast), 64'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int s, t;
      logic seen;
      areset = 1'b1;
      s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0;
      vae_ready = 1'b1;
      repeat (3) @(negedge aclk);
      chk_all_zero("reset");
      areset = 1'b0;

      // nominal, back-to-back
      s = start_cnt; load_packet(0); finish_packet("nominal", s, 1'b0);

      // tvalid every other cycle
      s = start_cnt; load_packet(1); finish_packet("gaps", s, 1'b0);

      // core not ready for 10 cycles after load
      vae_ready = 1'b0;
      s = start_cnt; load_packet(0);
      seen = 1'b0;
      repeat (10) begin @(negedge aclk); if (vae_start === 1'b1) seen = 1'b1; end
      chk("start_held_low", 64'(seen), 64'h0);
      vae_ready = 1'b1;
      @(negedge aclk); chk("start_pulse", 64'(vae_start), 64'h1);
      @(negedge aclk); chk("start_one_cycle", 64'(vae_start), 64'h0);
      finish_packet("ready", s, 1'b0);

      // downstream stall on the third result beat
      t = n_stall;
      stall_beat = beats_seen + 2; stall_left = 5;
      s = start_cnt; load_packet(0); finish_packet("stall", s, 1'b0);
      chk("stall_cycles", 64'(n_stall - t), 64'h5);

      // early tlast on beat 5: restart at wb2_m addr 0, error sticks
      s = start_cnt;
      for (int k = 0; k < 5; k++) send_beat(k, k == 4, 0, k);
      chk("early_tlast_err", 64'(err_tlast), 64'h1);
      load_packet(0); finish_packet("early", s, 1'b1);

      // reset while the core runs, then a clean packet
      s = start_cnt; load_packet(0);
      t = 0;
      while (start_cnt == s && t < 200) begin @(negedge aclk); t++; end
      chk("run_reached", 64'(t < 200), 64'h1);
      repeat (3) @(negedge aclk);
      areset = 1'b1;
      @(negedge aclk);
      chk_all_zero("midreset");
      out_q.delete();
      areset = 1'b0;
      s = start_cnt; load_packet(0); finish_packet("postreset", s, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
